// File: rtl/main_vc_dispatch_if.sv
// Handshake bundle between the main FIFO, the VC dispatcher and the two VC FIFOs.
// master = dispatcher side, slave = FIFO side.
interface main_vc_dispatch_if #(
  parameter int DATA_SIZE = 6
);
  logic                 fifo_empty_main;
  logic [DATA_SIZE-1:0] data_main;
  logic                 vc0_pause;
  logic                 vc1_pause;
  logic                 pop_main;
  logic                 push_vc0;
  logic                 push_vc1;
  logic [DATA_SIZE-1:0] data_vc0;
  logic [DATA_SIZE-1:0] data_vc1;

  modport master (
    input  fifo_empty_main, data_main, vc0_pause, vc1_pause,
    output pop_main, push_vc0, push_vc1, data_vc0, data_vc1
  );

  modport slave (
    output fifo_empty_main, data_main, vc0_pause, vc1_pause,
    input  pop_main, push_vc0, push_vc1, data_vc0, data_vc1
  );
endinterface

// File: rtl/main_vc_dispatch.sv
// Pops words from the main FIFO and routes each to VC0/VC1 by one select bit.
// Optional per-VC word counters are built only when DISPATCH_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a word and both VCs unpaused
// FETCH | pop issued last cycle, capturing data_main into hold_reg
// ROUTE | pushing hold_reg to its VC once that VC is unpaused
module main_vc_dispatch #(
  parameter int DATA_SIZE  = 6,
  parameter int VC_SEL_BIT = 4,
  parameter int CNT_SIZE   = 8
) (
  input  logic                clk,
  input  logic                reset,
  main_vc_dispatch_if.master  bus,
  output logic                busy,
  output logic [CNT_SIZE-1:0] words_vc0,
  output logic [CNT_SIZE-1:0] words_vc1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ROUTE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DATA_SIZE-1:0] hold_reg;
  logic                 can_pop;
  logic                 dest;
  logic                 dest_pause;
  logic                 pop_c;
  logic                 push0_c;
  logic                 push1_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        hold_reg <= bus.data_main;
      end
    end
  end

  // The destination is unknown until data returns, so a pop needs both VCs free.
  assign can_pop    = !bus.fifo_empty_main && !bus.vc0_pause && !bus.vc1_pause;
  assign dest       = hold_reg[VC_SEL_BIT];
  assign dest_pause = dest ? bus.vc1_pause : bus.vc0_pause;

  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    push0_c   = 1'b0;
    push1_c   = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop_c     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = ROUTE;
      end
      ROUTE: begin
        if (!dest_pause) begin
          push0_c = !dest;
          push1_c = dest;
          if (can_pop) begin
            pop_c     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Strobes stay quiet for the whole reset cycle, whatever state we are in.
    if (reset) begin
      pop_c   = 1'b0;
      push0_c = 1'b0;
      push1_c = 1'b0;
    end
  end

  assign bus.pop_main = pop_c;
  assign bus.push_vc0 = push0_c;
  assign bus.push_vc1 = push1_c;
  assign bus.data_vc0 = hold_reg;
  assign bus.data_vc1 = hold_reg;
  assign busy         = (state != IDLE) && !reset;

`ifdef DISPATCH_STATS_EN
  logic [CNT_SIZE-1:0] cnt_vc0;
  logic [CNT_SIZE-1:0] cnt_vc1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else begin
      if (push0_c) begin
        cnt_vc0 <= cnt_vc0 + CNT_SIZE'(1);
      end
      if (push1_c) begin
        cnt_vc1 <= cnt_vc1 + CNT_SIZE'(1);
      end
    end
  end

  assign words_vc0 = cnt_vc0;
  assign words_vc1 = cnt_vc1;
`else
  assign words_vc0 = '0;
  assign words_vc1 = '0;
`endif

endmodule

// File: tb/tb_main_vc_dispatch.sv
// Bench for main_vc_dispatch: directed scenarios then random traffic against a
// queue-based FIFO/scoreboard model. Counter expectations follow DISPATCH_STATS_EN.
module tb_main_vc_dispatch;
  localparam int DS  = 6;
  localparam int SEL = 4;
  localparam int CS  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic [CS-1:0] words_vc0;
  logic [CS-1:0] words_vc1;

  always #5 clk = ~clk;

  main_vc_dispatch_if #(.DATA_SIZE(DS)) bus ();

  main_vc_dispatch #(
    .DATA_SIZE (DS),
    .VC_SEL_BIT(SEL),
    .CNT_SIZE  (CS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master),
    .busy     (busy),
    .words_vc0(words_vc0),
    .words_vc1(words_vc1)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [DS-1:0] main_q[$];
  logic [DS-1:0] sb_q[$];
  logic          nxt_reset, nxt_p0, nxt_p1;
  logic          pop_s = 1'b0;
  logic          push0_s, push1_s, busy_s, empty_s, p0_s, p1_s, rst_s;
  logic [DS-1:0] d0_s, d1_s;
  logic [CS-1:0] w0_s, w1_s;
  logic [CS-1:0] m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CS-1:0] exp_cnt(input logic [CS-1:0] m);
`ifdef DISPATCH_STATS_EN
    return m;
`else
    return '0;
`endif
  endfunction

  // One clock: inputs change 1ns after posedge, outputs are sampled at negedge.
  task automatic cyc();
    logic [DS-1:0] w;
    @(posedge clk);
    #1;
    reset         = nxt_reset;
    bus.vc0_pause = nxt_p0;
    bus.vc1_pause = nxt_p1;
    if (pop_s && main_q.size() > 0) bus.data_main = main_q.pop_front();
    bus.fifo_empty_main = (main_q.size() == 0);
    @(negedge clk);
    pop_s   = bus.pop_main;
    push0_s = bus.push_vc0;
    push1_s = bus.push_vc1;
    d0_s    = bus.data_vc0;
    d1_s    = bus.data_vc1;
    busy_s  = busy;
    w0_s    = words_vc0;
    w1_s    = words_vc1;
    empty_s = bus.fifo_empty_main;
    p0_s    = bus.vc0_pause;
    p1_s    = bus.vc1_pause;
    rst_s   = reset;
    if (rst_s) begin
      sb_q.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end
    chk("push_exclusive", {31'd0, push0_s & push1_s}, 32'd0);
    chk("pop_while_empty", {31'd0, pop_s & empty_s}, 32'd0);
    chk("pop_while_paused", {31'd0, pop_s & (p0_s | p1_s)}, 32'd0);
    chk("push_vc0_paused", {31'd0, push0_s & p0_s}, 32'd0);
    chk("push_vc1_paused", {31'd0, push1_s & p1_s}, 32'd0);
    chk("data_vc_equal", {26'd0, d0_s}, {26'd0, d1_s});
    if (push0_s || push1_s) begin
      if (sb_q.size() == 0) begin
        chk("push_unexpected", 32'd1, 32'd0);
      end else begin
        w = sb_q.pop_front();
        chk("push_dest", {31'd0, push1_s}, {31'd0, w[SEL]});
        chk("push_data", {26'd0, (push1_s ? d1_s : d0_s)}, {26'd0, w});
        if (w[SEL]) m_cnt1 = m_cnt1 + 1'b1;
        else        m_cnt0 = m_cnt0 + 1'b1;
      end
    end
    if (pop_s && main_q.size() > 0) sb_q.push_back(main_q[0]);
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    nxt_p0 = 1'b0;
    nxt_p1 = 1'b0;
    do begin
      cyc();
      n++;
    end while (!(main_q.size() == 0 && sb_q.size() == 0 && !busy_s && !pop_s) && n < limit);
    chk(tag, {31'd0, n < limit}, 32'd1);
  endtask

  initial begin
    logic [7:0] ep, ep0, ep1, eb;
    reset = 1'b1;
    nxt_reset = 1'b1;
    nxt_p0 = 1'b0;
    nxt_p1 = 1'b0;
    bus.vc0_pause = 1'b0;
    bus.vc1_pause = 1'b0;
    bus.data_main = '0;
    bus.fifo_empty_main = 1'b1;
    m_cnt0 = '0;
    m_cnt1 = '0;

    // Reset with a non-empty main FIFO
    main_q.push_back(6'b010101);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_pop", {31'd0, pop_s}, 32'd0);
      chk("rst_push", {30'd0, push0_s, push1_s}, 32'd0);
      chk("rst_busy", {31'd0, busy_s}, 32'd0);
      chk("rst_data", {26'd0, d0_s}, 32'd0);
      chk("rst_words", {16'd0, w0_s, w1_s}, 32'd0);
    end

    // Single word to VC1
    nxt_reset = 1'b0;
    cyc();
    chk("single_pop_c0", {31'd0, pop_s}, 32'd1);
    chk("single_busy_c0", {31'd0, busy_s}, 32'd0);
    cyc();
    chk("single_pop_c1", {31'd0, pop_s}, 32'd0);
    chk("single_busy_c1", {31'd0, busy_s}, 32'd1);
    cyc();
    chk("single_push1_c2", {31'd0, push1_s}, 32'd1);
    chk("single_push0_c2", {31'd0, push0_s}, 32'd0);
    chk("single_data_c2", {26'd0, d1_s}, 32'h15);
    cyc();
    chk("single_busy_c3", {31'd0, busy_s}, 32'd0);
    chk("single_words1", {24'd0, w1_s}, {24'd0, exp_cnt(8'd1)});

    // Back-to-back: 05 -> VC0, 12 -> VC1, 07 -> VC0
    main_q.push_back(6'h05);
    main_q.push_back(6'h12);
    main_q.push_back(6'h07);
    ep  = 8'b0001_0101;
    ep0 = 8'b0100_0100;
    ep1 = 8'b0001_0000;
    eb  = 8'b0111_1110;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("b2b_pop_c%0d", i), {31'd0, pop_s}, {31'd0, ep[i]});
      chk($sformatf("b2b_push0_c%0d", i), {31'd0, push0_s}, {31'd0, ep0[i]});
      chk($sformatf("b2b_push1_c%0d", i), {31'd0, push1_s}, {31'd0, ep1[i]});
      chk($sformatf("b2b_busy_c%0d", i), {31'd0, busy_s}, {31'd0, eb[i]});
    end
    chk("b2b_words0", {24'd0, w0_s}, {24'd0, exp_cnt(8'd2)});
    chk("b2b_words1", {24'd0, w1_s}, {24'd0, exp_cnt(8'd2)});

    // Destination stall: 03 held while vc0_pause is high for 5 cycles
    main_q.push_back(6'h03);
    main_q.push_back(6'h1A);
    cyc();
    chk("stall_pop_c0", {31'd0, pop_s}, 32'd1);
    cyc();
    nxt_p0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_no_push", {30'd0, push0_s, push1_s}, 32'd0);
      chk("stall_no_pop", {31'd0, pop_s}, 32'd0);
      chk("stall_hold", {26'd0, d0_s}, 32'h03);
      chk("stall_busy", {31'd0, busy_s}, 32'd1);
    end
    nxt_p0 = 1'b0;
    cyc();
    chk("stall_release_push0", {31'd0, push0_s}, 32'd1);
    chk("stall_release_data", {26'd0, d0_s}, 32'h03);
    chk("stall_release_pop", {31'd0, pop_s}, 32'd1);
    cyc();
    cyc();
    chk("stall_next_push1", {31'd0, push1_s}, 32'd1);
    chk("stall_next_data", {26'd0, d1_s}, 32'h1A);
    cyc();
    chk("stall_idle", {31'd0, busy_s}, 32'd0);

    // Pop gating on the non-destination pause
    nxt_p1 = 1'b1;
    cyc();
    main_q.push_back(6'h0B);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gate_no_pop", {31'd0, pop_s}, 32'd0);
    end
    nxt_p1 = 1'b0;
    cyc();
    chk("gate_pop", {31'd0, pop_s}, 32'd1);
    cyc();
    cyc();
    chk("gate_push0", {31'd0, push0_s}, 32'd1);
    chk("gate_data", {26'd0, d0_s}, 32'h0B);
    cyc();

    // Reset while a word is stalled in ROUTE
    main_q.push_back(6'h02);
    cyc();
    chk("rroute_pop", {31'd0, pop_s}, 32'd1);
    cyc();
    nxt_p0 = 1'b1;
    cyc();
    chk("rroute_held_busy", {31'd0, busy_s}, 32'd1);
    chk("rroute_held_push", {31'd0, push0_s}, 32'd0);
    nxt_reset = 1'b1;
    cyc();
    chk("rroute_rst_push", {30'd0, push0_s, push1_s}, 32'd0);
    chk("rroute_rst_busy", {31'd0, busy_s}, 32'd0);
    nxt_reset = 1'b0;
    cyc();
    chk("rroute_idle", {31'd0, busy_s}, 32'd0);
    chk("rroute_words", {16'd0, w0_s, w1_s}, 32'd0);
    nxt_p0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rroute_discarded", {30'd0, push0_s, push1_s}, 32'd0);
      chk("rroute_stays_idle", {31'd0, busy_s}, 32'd0);
    end

    // 2^CNT_SIZE dispatches to VC0 wrap the counter
    for (int i = 0; i < (1 << CS); i++) main_q.push_back(DS'($urandom) & 6'h2F);
    drain("wrap_drain", 1200);
    chk("wrap_words0", {24'd0, w0_s}, 32'd0);
    chk("wrap_words0_model", {24'd0, w0_s}, {24'd0, exp_cnt(m_cnt0)});
    chk("wrap_words1", {24'd0, w1_s}, 32'd0);

    // Random traffic with random pauses and FIFO gaps
    for (int i = 0; i < 1500; i++) begin
      if (main_q.size() < 4 && $urandom_range(0, 2) != 0) main_q.push_back(DS'($urandom));
      nxt_p0 = ($urandom_range(0, 3) == 0);
      nxt_p1 = ($urandom_range(0, 3) == 0);
      cyc();
    end
    drain("rand_drain", 200);
    chk("rand_words0", {24'd0, w0_s}, {24'd0, exp_cnt(m_cnt0)});
    chk("rand_words1", {24'd0, w1_s}, {24'd0, exp_cnt(m_cnt1)});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
